// File: rtl/countdown_timer_ctrl.sv
// MM:SS countdown timer sequencer: set/run/pause/alarm control with BCD time
// registers, driven by the clock_set one-second strobe and button pulses.
module countdown_timer_ctrl #(
  parameter int unsigned ALARM_SEC = 10,
  parameter int unsigned MAX_MIN10 = 5
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clk_sec,
  input  logic       btn_start,
  input  logic       btn_clear,
  input  logic       btn_inc_sec,
  input  logic       btn_inc_min,
  output logic [3:0] min10,
  output logic [3:0] min1,
  output logic [3:0] sec10,
  output logic [3:0] sec1,
  output logic [1:0] state,
  output logic       alarm,
  output logic       done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_ALARM = 2'b11
  } state_t;

  localparam logic [3:0] MIN10_TOP = 4'(MAX_MIN10);
  localparam logic [7:0] ALARM_TOP = 8'(ALARM_SEC);

  state_t     state_q, state_d;
  logic [3:0] min10_q, min1_q, sec10_q, sec1_q;
  logic [3:0] dec_min10, dec_min1, dec_sec10, dec_sec1;
  logic [3:0] inc_min10, inc_min1, inc_sec10, inc_sec1;
  logic [7:0] acnt_q;
  logic       done_q;
  logic       any_btn, time_zero, expire, alarm_end, enter_alarm;

  assign any_btn     = btn_start | btn_clear | btn_inc_sec | btn_inc_min;
  assign time_zero   = (min10_q == '0) && (min1_q == '0) && (sec10_q == '0) && (sec1_q == '0);
  // Remaining time of 00:01 (or 00:00) means this strobe finishes the countdown.
  assign expire      = (min10_q == '0) && (min1_q == '0) && (sec10_q == '0) && (sec1_q <= 4'd1);
  assign alarm_end   = clk_sec && ((acnt_q + 8'd1) == ALARM_TOP);
  assign enter_alarm = (state_q == S_RUN) && (state_d == S_ALARM);

  // BCD decrement with borrow chain and BCD increments with wrap (no carry sec->min)
  always_comb begin
    dec_min10 = min10_q;
    dec_min1  = min1_q;
    dec_sec10 = sec10_q;
    dec_sec1  = sec1_q;
    if (sec1_q != '0) begin
      dec_sec1 = sec1_q - 4'd1;
    end else begin
      dec_sec1 = 4'd9;
      if (sec10_q != '0) begin
        dec_sec10 = sec10_q - 4'd1;
      end else begin
        dec_sec10 = 4'd5;
        if (min1_q != '0) begin
          dec_min1 = min1_q - 4'd1;
        end else begin
          dec_min1  = 4'd9;
          dec_min10 = min10_q - 4'd1;
        end
      end
    end

    inc_sec10 = sec10_q;
    inc_sec1  = sec1_q + 4'd1;
    if (sec1_q == 4'd9) begin
      inc_sec1  = '0;
      inc_sec10 = (sec10_q == 4'd5) ? '0 : sec10_q + 4'd1;
    end

    inc_min10 = min10_q;
    inc_min1  = min1_q + 4'd1;
    if (min1_q == 4'd9) begin
      inc_min1  = '0;
      inc_min10 = (min10_q == MIN10_TOP) ? '0 : min10_q + 4'd1;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic, priority clear > start > inc > clk_sec
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (!btn_clear && btn_start && !time_zero) state_d = S_RUN;
      end
      S_RUN: begin
        if (btn_clear)                 state_d = S_IDLE;
        else if (btn_start)            state_d = S_PAUSE;
        else if (clk_sec && expire)    state_d = S_ALARM;
      end
      S_PAUSE: begin
        if (btn_clear)                 state_d = S_IDLE;
        else if (btn_start)            state_d = S_RUN;
      end
      S_ALARM: begin
        if (any_btn || alarm_end)      state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Time digit registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      {min10_q, min1_q, sec10_q, sec1_q} <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (btn_clear) begin
            {min10_q, min1_q, sec10_q, sec1_q} <= '0;
          end else if (!btn_start) begin
            if (btn_inc_sec) {sec10_q, sec1_q} <= {inc_sec10, inc_sec1};
            if (btn_inc_min) {min10_q, min1_q} <= {inc_min10, inc_min1};
          end
        end
        S_RUN: begin
          if (btn_clear || (!btn_start && clk_sec && expire))
            {min10_q, min1_q, sec10_q, sec1_q} <= '0;
          else if (!btn_start && clk_sec)
            {min10_q, min1_q, sec10_q, sec1_q} <= {dec_min10, dec_min1, dec_sec10, dec_sec1};
        end
        S_PAUSE: begin
          if (btn_clear) {min10_q, min1_q, sec10_q, sec1_q} <= '0;
        end
        default: begin
          {min10_q, min1_q, sec10_q, sec1_q} <= '0;
        end
      endcase
    end
  end

  // Alarm duration counter and done pulse
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      acnt_q <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= enter_alarm;
      if (enter_alarm)
        acnt_q <= '0;
      else if ((state_q == S_ALARM) && clk_sec && !any_btn)
        acnt_q <= acnt_q + 8'd1;
    end
  end

  // Output decode
  always_comb begin
    state = state_q;
    alarm = (state_q == S_ALARM);
    done  = done_q;
    min10 = min10_q;
    min1  = min1_q;
    sec10 = sec10_q;
    sec1  = sec1_q;
  end

endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// Bench for countdown_timer_ctrl: seconds-based reference model checked every
// cycle, plus directed literal expectations along the set/run/pause/alarm paths.
module tb_countdown_timer_ctrl;

  localparam int ALARM_SEC = 10;
  localparam int MAX_MIN10 = 5;

  logic       clk = 1'b0;
  logic       reset_n, clk_sec, btn_start, btn_clear, btn_inc_sec, btn_inc_min;
  logic [3:0] min10, min1, sec10, sec1;
  logic [1:0] state;
  logic       alarm, done;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  // Model: remaining time kept as total seconds, state as 0..3
  int m_t = 0, m_st = 0, m_cnt = 0;
  bit m_done = 1'b0;

  countdown_timer_ctrl #(.ALARM_SEC(ALARM_SEC), .MAX_MIN10(MAX_MIN10)) dut (
    .clk(clk), .reset_n(reset_n), .clk_sec(clk_sec),
    .btn_start(btn_start), .btn_clear(btn_clear),
    .btn_inc_sec(btn_inc_sec), .btn_inc_min(btn_inc_min),
    .min10(min10), .min1(min1), .sec10(sec10), .sec1(sec1),
    .state(state), .alarm(alarm), .done(done)
  );

  always #4 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    int m, s;
    m_done = 1'b0;
    if (!reset_n) begin
      m_st = 0; m_t = 0; m_cnt = 0;
    end else begin
      case (m_st)
        0: begin
          if (btn_clear) m_t = 0;
          else if (btn_start) begin
            if (m_t != 0) m_st = 1;
          end else begin
            m = m_t / 60; s = m_t % 60;
            if (btn_inc_sec) s = (s + 1) % 60;
            if (btn_inc_min) m = (m + 1) % (10 * (MAX_MIN10 + 1));
            m_t = m * 60 + s;
          end
        end
        1: begin
          if (btn_clear) begin m_st = 0; m_t = 0; end
          else if (btn_start) m_st = 2;
          else if (clk_sec) begin
            m_t = m_t - 1;
            if (m_t == 0) begin m_st = 3; m_done = 1'b1; m_cnt = 0; end
          end
        end
        2: begin
          if (btn_clear) begin m_st = 0; m_t = 0; end
          else if (btn_start) m_st = 1;
        end
        default: begin
          if (btn_start || btn_clear || btn_inc_sec || btn_inc_min) m_st = 0;
          else if (clk_sec) begin
            m_cnt++;
            if (m_cnt == ALARM_SEC) m_st = 0;
          end
        end
      endcase
    end
  end

  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      chk("m_min10", min10, (m_t / 60) / 10);
      chk("m_min1",  min1,  (m_t / 60) % 10);
      chk("m_sec10", sec10, (m_t % 60) / 10);
      chk("m_sec1",  sec1,  (m_t % 60) % 10);
      chk("m_state", state, m_st);
      chk("m_alarm", alarm, (m_st == 3) ? 1 : 0);
      chk("m_done",  done,  m_done);
    end
  end

  task automatic step(input logic c, input logic s, input logic is, input logic im, input logic cs);
    btn_clear = c; btn_start = s; btn_inc_sec = is; btn_inc_min = im; clk_sec = cs;
    @(posedge clk); #1;
    btn_clear = 1'b0; btn_start = 1'b0; btn_inc_sec = 1'b0; btn_inc_min = 1'b0; clk_sec = 1'b0;
  endtask

  task automatic expect_dut(input string name, input int m10, input int m1, input int s10,
                            input int s1, input int st, input int al, input int dn);
    chk({name, "_min10"}, min10, m10);
    chk({name, "_min1"},  min1,  m1);
    chk({name, "_sec10"}, sec10, s10);
    chk({name, "_sec1"},  sec1,  s1);
    chk({name, "_state"}, state, st);
    chk({name, "_alarm"}, alarm, al);
    chk({name, "_done"},  done,  dn);
  endtask

  initial begin
    reset_n = 1'b0;
    btn_clear = 1'b0; btn_start = 1'b0; btn_inc_sec = 1'b0; btn_inc_min = 1'b0; clk_sec = 1'b0;
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk_en = 1'b1;
    expect_dut("rst", 0, 0, 0, 0, 0, 0, 0);
    reset_n = 1'b1;

    // Reset mid-RUN at 03:27
    repeat (3) step(0, 0, 0, 1, 0);
    repeat (27) step(0, 0, 1, 0, 0);
    step(0, 1, 0, 0, 0);
    expect_dut("run_0327", 0, 3, 2, 7, 1, 0, 0);
    reset_n = 1'b0;
    step(0, 0, 0, 0, 0);
    expect_dut("rst_run", 0, 0, 0, 0, 0, 0, 0);
    reset_n = 1'b1;

    // Set-mode wrapping
    repeat (61) step(0, 0, 1, 0, 0);
    expect_dut("sec_wrap", 0, 0, 0, 1, 0, 0, 0);
    repeat (3) step(0, 0, 0, 1, 0);
    expect_dut("min3", 0, 3, 0, 1, 0, 0, 0);
    step(0, 0, 1, 1, 0);
    expect_dut("both_inc", 0, 4, 0, 2, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    expect_dut("idle_csec", 0, 4, 0, 2, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    repeat (59) step(0, 0, 0, 1, 0);
    expect_dut("min_59", 5, 9, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    expect_dut("min_wrap", 0, 0, 0, 0, 0, 0, 0);

    // Borrow chain
    repeat (10) step(0, 0, 0, 1, 0);
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    expect_dut("borrow_10", 0, 9, 5, 9, 1, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    expect_dut("borrow_01", 0, 0, 5, 9, 1, 0, 0);
    step(1, 0, 0, 0, 0);

    // Expiry and alarm duration
    repeat (2) step(0, 0, 1, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    expect_dut("exp_01", 0, 0, 0, 1, 1, 0, 0);
    step(0, 0, 0, 0, 1);
    expect_dut("exp_alarm", 0, 0, 0, 0, 3, 1, 1);
    step(0, 0, 0, 0, 0);
    expect_dut("exp_done_off", 0, 0, 0, 0, 3, 1, 0);
    repeat (9) begin
      step(0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0);
    end
    expect_dut("alarm_9", 0, 0, 0, 0, 3, 1, 0);
    step(0, 0, 0, 0, 1);
    expect_dut("alarm_10", 0, 0, 0, 0, 0, 0, 0);

    // Pause and priority
    repeat (31) step(0, 0, 1, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    expect_dut("run_30", 0, 0, 3, 0, 1, 0, 0);
    step(0, 1, 0, 0, 1);
    expect_dut("pause", 0, 0, 3, 0, 2, 0, 0);
    repeat (5) step(0, 0, 0, 0, 1);
    step(0, 0, 1, 1, 0);
    expect_dut("pause_frz", 0, 0, 3, 0, 2, 0, 0);
    step(0, 1, 0, 0, 0);
    expect_dut("resume", 0, 0, 3, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1);
    expect_dut("resume_dec", 0, 0, 2, 9, 1, 0, 0);
    step(1, 1, 0, 0, 0);
    expect_dut("clr_start", 0, 0, 0, 0, 0, 0, 0);

    // Start at zero, alarm cancel by button
    step(0, 1, 0, 0, 0);
    expect_dut("start_zero", 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    expect_dut("alarm2", 0, 0, 0, 0, 3, 1, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 1, 0, 0);
    expect_dut("cancel", 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    expect_dut("after_cancel", 0, 0, 0, 1, 0, 0, 0);

    // Reset mid-ALARM
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    reset_n = 1'b0;
    step(0, 0, 0, 0, 0);
    expect_dut("rst_alarm", 0, 0, 0, 0, 0, 0, 0);
    reset_n = 1'b1;
    step(0, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
